// File: rtl/fifo_ptr_flag_gen_if.sv
// Handshake/status bundle between a FIFO port and its pointer/flag engine.
interface fifo_ptr_flag_gen_if #(
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  inc;
    logic [ADDR_WIDTH:0]   sync_gray_ptr;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   gray_ptr;
    logic                  flag;
    logic                  almost;
    logic [ADDR_WIDTH:0]   level;

    // Master is the FIFO port logic; slave is the pointer/flag engine.
    modport master (
        output inc, sync_gray_ptr,
        input  accept, addr, gray_ptr, flag, almost, level
    );

    modport slave (
        input  inc, sync_gray_ptr,
        output accept, addr, gray_ptr, flag, almost, level
    );
endinterface

// File: rtl/fifo_ptr_flag_gen.sv
// Pointer/flag engine for one side of an async FIFO. MODE 0 is the write side (flag = full),
// MODE 1 the read side (flag = empty). Flags and level are derived from the next-state pointer
// so they register on the same edge as the pointer itself.
module fifo_ptr_flag_gen #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned MODE       = 0,
    parameter int unsigned ALMOST_TH  = 2
) (
    input logic               clk,
    input logic               rst,
    fifo_ptr_flag_gen_if.slave bus
);
    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [PW-1:0] FULL_TH   = PW'(DEPTH - ALMOST_TH);
    localparam logic [PW-1:0] EMPTY_TH  = PW'(ALMOST_TH);
    // Full when the Gray pointers differ in exactly their top two bits.
    localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW - 2){1'b0}}};
    localparam logic          RST_FLAG  = (MODE != 0);
    localparam logic          RST_ALM   = (MODE != 0);

    logic [PW-1:0] bin_q, bin_d;
    logic [PW-1:0] gray_q, gray_d;
    logic [PW-1:0] level_q, level_d;
    logic          flag_q, flag_d;
    logic          almost_q, almost_d;
    logic [PW-1:0] sync_bin;
    logic          accept;

    assign accept = bus.inc & ~flag_q;

    // Gray-to-binary of the synchronized opposite pointer (running XOR from the MSB down).
    always_comb begin
        logic acc;
        acc      = 1'b0;
        sync_bin = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            acc         = acc ^ bus.sync_gray_ptr[i];
            sync_bin[i] = acc;
        end
    end

    // Next pointer, its Gray code, and the flags/level that follow from it.
    always_comb begin
        bin_d  = bin_q + {{(PW - 1){1'b0}}, accept};
        gray_d = bin_d ^ (bin_d >> 1);
        if (MODE == 0) begin
            level_d  = bin_d - sync_bin;
            flag_d   = (gray_d == (bus.sync_gray_ptr ^ FULL_MASK));
            almost_d = (level_d >= FULL_TH);
        end else begin
            level_d  = sync_bin - bin_d;
            flag_d   = (gray_d == bus.sync_gray_ptr);
            almost_d = (level_d <= EMPTY_TH);
        end
    end

    // Pointer, Gray pointer and status registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q    <= '0;
            gray_q   <= '0;
            level_q  <= '0;
            flag_q   <= RST_FLAG;
            almost_q <= RST_ALM;
        end else begin
            bin_q    <= bin_d;
            gray_q   <= gray_d;
            level_q  <= level_d;
            flag_q   <= flag_d;
            almost_q <= almost_d;
        end
    end

    assign bus.accept   = accept;
    assign bus.addr     = bin_q[ADDR_WIDTH-1:0];
    assign bus.gray_ptr = gray_q;
    assign bus.flag     = flag_q;
    assign bus.almost   = almost_q;
    assign bus.level    = level_q;

endmodule

// File: doc/fifo_ptr_flag_gen.md
Name: fifo_ptr_flag_gen

Overview:
Parametrised pointer/flag engine for one side of the async FIFO.
- Keeps a registered binary pointer and emits its registered Gray encoding for crossing to the other clock domain.
- Decodes the synchronized Gray pointer from the opposite domain back to binary.
- Produces registered full or empty, almost-full or almost-empty, and fill level.
- MODE selects write-side or read-side behaviour, so one module serves both FIFO ports.

Parameters:
ADDR_WIDTH, 3, memory address width; depth DEPTH = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; legal range ≥2.
MODE, 0, 0 = write side (FLAG means full); 1 = read side (FLAG means empty).
ALMOST_TH, 2, almost threshold in entries; legal range 0..DEPTH.

Ports:
CLK  input  1  side clock, rising edge.
RST  input  1  asynchronous, active-high reset.
INC  input  1  push request (MODE 0) or pop request (MODE 1).
SYNC_GRAY_PTR  input  ADDR_WIDTH+1  opposite-domain Gray pointer, already 2-FF synchronized.
ACCEPT  output  1  combinational, INC & ~FLAG; pointer advances on this edge.
ADDR  output  ADDR_WIDTH  memory address, equal to bin_ptr[ADDR_WIDTH-1:0].
GRAY_PTR  output  ADDR_WIDTH+1  registered Gray pointer, sent for synchronization.
FLAG  output  1  registered full (MODE 0) or empty (MODE 1).
ALMOST  output  1  registered almost-full (MODE 0) or almost-empty (MODE 1).
LEVEL  output  ADDR_WIDTH+1  registered fill level, 0..DEPTH.

Behaviour:
- Reset (RST=1, asynchronous, takes effect immediately):
  - bin_ptr, GRAY_PTR and LEVEL clear to 0.
  - FLAG = MODE (0 = not full; 1 = empty).
  - ALMOST = 0 in MODE 0; ALMOST = 1 in MODE 1 when ALMOST_TH ≥ 0, i.e. always 1.
- Reset mid-operation: all state clears at once; no partial increment completes.
- bin_next = bin_ptr + ACCEPT, modulo 2^(ADDR_WIDTH+1). Wrap from all-ones to 0 is silent.
- gray_next = bin_next ^ (bin_next >> 1).
- bin_ptr and GRAY_PTR register bin_next and gray_next on the rising CLK edge.
- Required property: at most one GRAY_PTR bit toggles per cycle, including at wrap.
- sync_bin is combinational Gray-to-binary of SYNC_GRAY_PTR:
  - sync_bin[MSB] = g[MSB].
  - sync_bin[i] = sync_bin[i+1] ^ g[i], for i descending.
- Flags and LEVEL are computed from the next-state pointer and registered on the same edge as the pointer. They have zero extra latency relative to the pointer.
- MODE 0 (write side):
  - full_next = (gray_next == {~SYNC_GRAY_PTR[MSB:MSB-1], SYNC_GRAY_PTR[MSB-2:0]}).
  - level = bin_next − sync_bin, modulo 2^(ADDR_WIDTH+1).
  - ALMOST = (level ≥ DEPTH − ALMOST_TH).
- MODE 1 (read side):
  - empty_next = (gray_next == SYNC_GRAY_PTR).
  - level = sync_bin − bin_next, modulo 2^(ADDR_WIDTH+1).
  - ALMOST = (level ≤ ALMOST_TH).
- INC while FLAG=1: ACCEPT=0 and the pointer holds. Flags and LEVEL still update from SYNC_GRAY_PTR movement.
- INC together with an opposite-pointer change in the same cycle: both contribute to the next-state flag and level. Example: a full write side that sees a read pointer advance deasserts FLAG at the next edge.
- Flags are pessimistic by design. Full and empty deassert only after the synchronized pointer arrives, which is the synchronizer latency upstream of this block.
- Out-of-range SYNC_GRAY_PTR (difference > DEPTH) is a protocol violation. LEVEL is then not saturated and its value is unspecified.

Test Plan:
1. MODE 0, ADDR_WIDTH 3, assert then release RST → ADDR=0, GRAY_PTR=0000, FLAG=0, ALMOST=0, LEVEL=0.
2. MODE 0, SYNC_GRAY_PTR=0000, INC held 9 cycles →
   - ALMOST rises on the edge where LEVEL reaches 6.
   - After the 8th edge: bin 1000, GRAY_PTR=1100, FLAG=1, LEVEL=8.
   - 9th cycle: ACCEPT=0 and the pointer holds.
   - Then set SYNC_GRAY_PTR=0001 → next edge FLAG=0, LEVEL=7.
3. MODE 1, reset → FLAG=1, ALMOST=1. Set SYNC_GRAY_PTR=0011 (binary 2) → next edge FLAG=0, LEVEL=2. Two INC cycles → FLAG=1, LEVEL=0, ADDR=2.
4. Wrap in MODE 1 with the opposite pointer kept 1 ahead, 16 accepted increments →
   - GRAY_PTR sequence 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000.
   - Exactly one bit changes per step.
5. Simultaneous events, MODE 0: full at LEVEL=8, INC=1 while SYNC_GRAY_PTR advances by one → ACCEPT=0 this cycle, FLAG=0 next edge, LEVEL=7. INC held → accepted next cycle, FLAG=1.
6. Mid-operation reset: at LEVEL=5, assert RST asynchronously between clock edges → all outputs return to their reset values before the next CLK edge.
